// File: rtl/serial_adder_pkg.sv
// Types shared by the serial adder: FSM state enum built on the shared encodings.
package serial_adder_pkg;
`include "serial_adder_defs.vh"

   typedef enum logic [1:0] {
      IDLE = SA_IDLE,
      RUN  = SA_RUN,
      DONE = SA_DONE
   } state_t;

endpackage

// File: rtl/full_adder_st2.sv
// Structural one-bit full adder built from gate-level logic only.
module full_adder_st2 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic axb;

   assign axb  = a ^ b;
   assign s    = axb ^ cin;
   assign cout = (a & b) | (cin & axb);

endmodule

// File: rtl/serial_adder_defs.vh
// Shared state encodings for the serial adder controller.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
localparam logic [1:0] SA_IDLE = 2'd0;
localparam logic [1:0] SA_RUN  = 2'd1;
localparam logic [1:0] SA_DONE = 2'd2;
`endif

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH clock edges.
//
//   state | meaning
//   IDLE  | waiting for start; last result held on sum/cout
//   RUN   | one bit per edge through the full adder, WIDTH edges total
//   DONE  | sum/cout valid, done pulses for one cycle, then back to IDLE
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] sumr;
   logic [WIDTH-1:0] sum_shift;
   logic             carry;
   logic             coutr;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             accept;
   logic             last;

   full_adder_st2 u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last = (cnt == LAST);

   // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_shift = fa_s;
      end else begin : g_sum_wn
         assign sum_shift = {fa_s, sumr[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         sumr  <= '0;
         carry <= 1'b0;
         coutr <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         opa   <= a;
         opb   <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         opa   <= opa >> 1;
         opb   <= opb >> 1;
         sumr  <= sum_shift;
         carry <= fa_c;
         cnt   <= cnt + CW'(1);
         if (last) begin
            coutr <= fa_c;
         end
      end
   end

   assign sum  = sumr;
   assign cout = coutr;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 operation; operands are scrambled after acceptance, and
   // optional stray start pulses land in cycle 3 (RUN) and cycle 8 (DONE).
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input bit pulse);
      int e;
      e      = int'(ta) + int'(tb) + int'(tc);
      a8     = ta;
      b8     = tb;
      cin8   = tc;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      chk("acc_busy", 32'(busy8), 32'd1);
      for (int k = 1; k <= 8; k++) begin
         a8     = 8'($urandom);
         b8     = 8'($urandom);
         cin8   = 1'($urandom);
         start8 = pulse && (k == 4);
         tick();
         start8 = 1'b0;
         if (k < 8) begin
            chk("run_busy", 32'(busy8), 32'd1);
            chk("run_done", 32'(done8), 32'd0);
         end else begin
            chk("done_pulse", 32'(done8), 32'd1);
            chk("done_busy", 32'(busy8), 32'd0);
            chk("sum", 32'(sum8), 32'(e & 'hff));
            chk("cout", 32'(cout8), 32'((e >> 8) & 1));
         end
      end
      start8 = pulse;
      tick();
      start8 = 1'b0;
      chk("idle_done", 32'(done8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
      chk("idle_sum", 32'(sum8), 32'(e & 'hff));
      chk("idle_cout", 32'(cout8), 32'((e >> 8) & 1));
      tick();
      chk("no_queue_busy", 32'(busy8), 32'd0);
      chk("no_queue_done", 32'(done8), 32'd0);
   endtask

   initial begin
      int e;
      int ndone;

      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_sum8", 32'(sum8), 32'd0);
      chk("rst_cout8", 32'(cout8), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_sum1", 32'(sum1), 32'd0);
      rst = 1'b0;
      tick();

      op8(8'h3C, 8'h0F, 1'b0, 1'b0);
      op8(8'hFF, 8'h01, 1'b0, 1'b0);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0);
      op8(8'h5A, 8'h33, 1'b1, 1'b1);
      op8(8'h00, 8'h00, 1'b0, 1'b0);

      // Abort mid-run: reset four cycles into RUN.
      a8 = 8'hA5; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("pre_abort_busy", 32'(busy8), 32'd1);
      rst = 1'b1;
      start8 = 1'b1;
      tick();
      rst = 1'b0;
      start8 = 1'b0;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_sum", 32'(sum8), 32'd0);
      chk("abort_cout", 32'(cout8), 32'd0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_idle", 32'(busy8), 32'd0);

      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      end

      // Start held high: period of 10 cycles, result held in the IDLE gap.
      a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
      tick();
      for (int c = 1; c <= 40; c++) begin
         tick();
         chk("held_done", 32'(done8), 32'((c % 10) == 8));
         chk("held_busy", 32'(busy8), 32'((c % 10) < 8));
         if ((c % 10) == 8 || (c % 10) == 9) begin
            chk("held_sum", 32'(sum8), 32'h03);
            chk("held_cout", 32'(cout8), 32'd0);
         end
      end
      start8 = 1'b0;
      for (int k = 0; k < 12; k++) tick();

      // WIDTH=1: exhaustive operands.
      for (int v = 7; v >= 0; v--) begin
         a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
         e  = (v >> 2 & 1) + (v >> 1 & 1) + (v & 1);
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
         chk("w1_busy", 32'(busy1), 32'd1);
         chk("w1_run_done", 32'(done1), 32'd0);
         tick();
         chk("w1_done", 32'(done1), 32'd1);
         chk("w1_sum", 32'(sum1), 32'(e & 1));
         chk("w1_cout", 32'(cout1), 32'((e >> 1) & 1));
         tick();
         chk("w1_idle", 32'(done1 | busy1), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
